// File: rtl/pc_jump_unit.sv
// Hack program counter with jump-condition evaluation.
// Optional tight-loop halt flag: define PC_HALT_DETECT_EN.
module pc_jump_unit #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             is_c,
  input  logic [2:0]       jump,
  input  logic             zr,
  input  logic             ng,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             taken,
  output logic             jumped,
  output logic             halted
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             jumped_q;
  logic             jumped_d;

  // jump condition; j1=lt, j2=eq, j3=gt
  always_comb begin
    taken = is_c & ((jump[2] & ng)
          | (jump[1] & zr)
          | (jump[0] & ~ng & ~zr));
  end

  // next state for an enabled, non-reset edge
  always_comb begin
    out_d    = out_q + {{(WIDTH-1){1'b0}}, 1'b1};
    jumped_d = 1'b0;
    if (taken) begin
      out_d    = in;
      jumped_d = 1'b1;
    end
  end

  // pc and jumped registers; reset beats enable
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= RESET_ADDR;
      jumped_q <= 1'b0;
    end else if (enable) begin
      out_q    <= out_d;
      jumped_q <= jumped_d;
    end
  end

`ifdef PC_HALT_DETECT_EN
  logic halted_q;
  logic halted_d;

  // sticky flag: jump onto itself
  always_comb begin
    halted_d = halted_q | (taken & (in == out_q));
  end

  // halt register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else if (enable) begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign out    = out_q;
  assign jumped = jumped_q;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Self-checking bench for pc_jump_unit.
// Vector table, halt sequence, randomized model check.
module tb_pc_jump_unit;

`ifdef PC_HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        is_c;
  logic [2:0]  jump;
  logic        zr;
  logic        ng;
  logic        enable;
  logic [15:0] out;
  logic        taken;
  logic        jumped;
  logic        halted;

  int tests;
  int fails;

  pc_jump_unit #(
    .WIDTH(16),
    .RESET_ADDR(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .is_c(is_c),
    .jump(jump),
    .zr(zr),
    .ng(ng),
    .enable(enable),
    .out(out),
    .taken(taken),
    .jumped(jumped),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        c;
    logic [2:0]  j;
    logic        z;
    logic        n;
    logic [15:0] tgt;
    logic        e_taken;
    logic [15:0] e_out;
    logic        e_jumped;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic c, input logic [2:0] j,
                       input logic z, input logic n,
                       input logic [15:0] t);
    reset = r; enable = e; is_c = c;
    jump = j; zr = z; ng = n; in = t;
  endtask

  function automatic logic cond(input logic c,
                                input logic [2:0] j,
                                input logic z,
                                input logic n);
    logic lt, eq, gt;
    lt = n;
    eq = z;
    gt = !n && !z;
    return c && ((j[2] && lt) || (j[1] && eq) || (j[0] && gt));
  endfunction

  function automatic vec_t mk(input logic r, input logic e,
                              input logic c, input logic [2:0] j,
                              input logic z, input logic n,
                              input logic [15:0] t,
                              input logic et,
                              input logic [15:0] eo,
                              input logic ej);
    vec_t v;
    v.rst = r; v.en = e; v.c = c; v.j = j; v.z = z; v.n = n;
    v.tgt = t; v.e_taken = et; v.e_out = eo; v.e_jumped = ej;
    return v;
  endfunction

  logic [15:0] m_out;
  logic        m_jmp;
  logic        m_halt;
  logic        t_exp;

  initial begin
    tests = 0;
    fails = 0;
    drive(1, 1, 0, 3'b000, 0, 0, 16'h0);

    vt[0]  = mk(1,1,0,3'b000,0,0,16'h0000, 0,16'h0000,0);
    vt[1]  = mk(1,1,0,3'b000,0,0,16'h0000, 0,16'h0000,0);
    vt[2]  = mk(0,1,0,3'b000,0,0,16'h0000, 0,16'h0001,0);
    vt[3]  = mk(0,1,0,3'b000,0,0,16'h0000, 0,16'h0002,0);
    vt[4]  = mk(0,1,0,3'b000,0,0,16'h0000, 0,16'h0003,0);
    vt[5]  = mk(0,1,0,3'b000,0,0,16'h0000, 0,16'h0004,0);
    vt[6]  = mk(0,1,0,3'b000,0,0,16'h0000, 0,16'h0005,0);
    vt[7]  = mk(0,1,1,3'b010,1,0,16'h0040, 1,16'h0040,1);
    vt[8]  = mk(0,1,1,3'b010,0,1,16'h0040, 0,16'h0041,0);
    vt[9]  = mk(0,1,1,3'b001,0,0,16'h0040, 1,16'h0040,1);
    vt[10] = mk(0,1,0,3'b111,1,1,16'h1234, 0,16'h0041,0);
    vt[11] = mk(0,0,0,3'b000,0,0,16'h0000, 0,16'h0041,0);
    vt[12] = mk(0,0,0,3'b000,0,0,16'h0000, 0,16'h0041,0);
    vt[13] = mk(0,0,0,3'b000,0,0,16'h0000, 0,16'h0041,0);
    vt[14] = mk(0,1,1,3'b111,0,1,16'hFFFF, 1,16'hFFFF,1);
    vt[15] = mk(0,0,1,3'b111,0,0,16'h0005, 1,16'hFFFF,1);
    vt[16] = mk(0,1,0,3'b000,0,0,16'h0000, 0,16'h0000,0);
    vt[17] = mk(1,1,1,3'b111,0,0,16'h0100, 1,16'h0000,0);

    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].rst, vt[i].en, vt[i].c, vt[i].j,
            vt[i].z, vt[i].n, vt[i].tgt);
      #1;
      chk($sformatf("vec%0d.taken", i), {31'b0, taken},
          {31'b0, vt[i].e_taken});
      @(posedge clk); #1;
      chk($sformatf("vec%0d.out", i), {16'b0, out},
          {16'b0, vt[i].e_out});
      chk($sformatf("vec%0d.jumped", i), {31'b0, jumped},
          {31'b0, vt[i].e_jumped});
      chk($sformatf("vec%0d.halted", i), {31'b0, halted}, 32'd0);
    end

    // illegal flags zr=ng=1: taken = j1|j2
    drive(0, 1, 1, 3'b001, 1, 1, 16'h0);
    #1 chk("illegal.j3", {31'b0, taken}, 32'd0);
    jump = 3'b100;
    #1 chk("illegal.j1", {31'b0, taken}, 32'd1);
    jump = 3'b000;
    #1 chk("illegal.none", {31'b0, taken}, 32'd0);

    // halt sequence
    drive(1, 1, 0, 3'b000, 0, 0, 16'h0);
    @(posedge clk); #1;
    drive(0, 1, 1, 3'b111, 0, 0, 16'h0010);
    @(posedge clk); #1;
    chk("halt.pre_out", {16'b0, out}, 32'h10);
    chk("halt.pre", {31'b0, halted}, 32'd0);
    @(posedge clk); #1;
    chk("halt.loop_out", {16'b0, out}, 32'h10);
    chk("halt.set", {31'b0, halted}, {31'b0, HD});
    drive(0, 1, 0, 3'b000, 0, 0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("halt.cnt_out", {16'b0, out}, 32'h13);
    chk("halt.sticky", {31'b0, halted}, {31'b0, HD});
    enable = 1'b0;
    @(posedge clk); #1;
    chk("halt.hold", {31'b0, halted}, {31'b0, HD});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("halt.clear", {31'b0, halted}, 32'd0);
    chk("halt.rst_out", {16'b0, out}, 32'h0);

    // randomized run against model
    m_out = 16'h0; m_jmp = 1'b0; m_halt = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(49) == 0,
            $urandom_range(3) != 0,
            $urandom_range(1) == 1,
            3'($urandom),
            $urandom_range(2) == 0,
            $urandom_range(2) == 0,
            ($urandom_range(3) == 0) ? m_out : 16'($urandom));
      if ($urandom_range(7) == 0) in = 16'hFFFF;
      t_exp = cond(is_c, jump, zr, ng);
      #1 chk("rnd.taken", {31'b0, taken}, {31'b0, t_exp});
      if (reset) begin
        m_out = 16'h0; m_jmp = 1'b0; m_halt = 1'b0;
      end else if (enable) begin
        if (t_exp && in == m_out && HD) m_halt = 1'b1;
        m_jmp = t_exp;
        m_out = t_exp ? in : m_out + 16'd1;
      end
      @(posedge clk); #1;
      chk("rnd.out", {16'b0, out}, {16'b0, m_out});
      chk("rnd.jumped", {31'b0, jumped}, {31'b0, m_jmp});
      chk("rnd.halted", {31'b0, halted}, {31'b0, m_halt});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_jump_unit.md
# pc_jump_unit

16-bit Hack program counter with integrated jump-condition evaluation. It sits directly downstream of the A-register (a Register16 instance): the A value is the jump target, and the C-instruction jump bits plus the ALU flags decide load versus increment. `out` drives the instruction ROM address each cycle.

## Interface

Parameters:
- `WIDTH`, 16: counter and target width. Must stay 16 for Hack compatibility.
- `RESET_ADDR`, 16'h0000: value loaded on reset.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  WIDTH  jump target, taken from the A-register output.
- `is_c`  input  1  current instruction is a C-instruction (instruction[15]); gates the jump bits.
- `jump`  input  3  jump bits {j1,j2,j3} (instruction[2:0]).
- `zr`  input  1  ALU output is zero.
- `ng`  input  1  ALU output is negative.
- `enable`  input  1  advance permitted; low freezes all state.
- `out`  output  WIDTH  current program counter (registered).
- `taken`  output  1  combinational: jump condition is true this cycle.
- `jumped`  output  1  registered: the last state update was a load from `in`.
- `halted`  output  1  registered, sticky: tight self-loop detected (see Configuration).

## Operation

- Jump condition: `taken = is_c & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr))`.
  - 3'b000 never jumps.
  - 3'b111 always jumps, regardless of flags.
  - `zr` and `ng` both high is illegal ALU output. The formula still applies as written, so `taken = j1 | j2`.
- Next-state priority on each rising edge, highest first:
  1. `reset`: out ← RESET_ADDR, jumped ← 0, halted ← 0.
  2. `~enable`: out, jumped and halted all hold.
  3. `taken`: out ← in, jumped ← 1.
  4. Otherwise: out ← out + 1 (modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000), jumped ← 0.
- `is_c` low (A-instruction) always increments, whatever the values of `jump`, `zr` and `ng`.
- Once `halted` is set, counting continues unchanged. The flag is advisory only and does not stall.

## Timing

- Reset values: out = RESET_ADDR, jumped = 0, halted = 0. `taken` is combinational and is not reset.
- Reset is sampled only on a clock edge. Reset asserted mid-run takes effect on the next edge, and reset wins over `enable` and `taken` on that same edge.
- Latency: one cycle. Inputs sampled at edge N appear on `out` and `jumped` after edge N.
- `taken` reflects the current inputs with zero latency. It must not be used to gate `clk`.
- The first edge with `reset` low advances from RESET_ADDR, using the normal priority rules.

## Configuration

- Macro: `PC_HALT_DETECT_EN`.
- Defined:
  - `halted` is set on an enabled, non-reset edge where `taken` is high and `in == out`. This is the Hack idiom `(END) @END; 0;JMP`.
  - Once set, `halted` stays high until reset.
- Undefined:
  - `halted` is tied to 0.
  - No comparator is synthesized.
  - The port list is unchanged.

## Test plan

- Reset then increment: hold reset 2 cycles, then release with enable=1 and is_c=0 for 5 cycles. Required: out = 0, then 1, 2, 3, 4, 5; jumped = 0 throughout.
- Conditional jumps with in=16'h0040:
  - jump=3'b010 (JEQ), zr=1 → out=16'h0040 next cycle, jumped=1.
  - jump=3'b010, zr=0, ng=1 → out increments, jumped=0.
  - jump=3'b001 (JGT), zr=0, ng=0 → out=16'h0040.
- Gating: is_c=0 with jump=3'b111 and in=16'h1234 → increments. enable=0 for 3 cycles → out, jumped and halted all hold.
- Wrap: load 16'hFFFF via JMP, then increment → out=16'h0000, jumped=0.
- Halt (macro defined): out=16'h0010, in=16'h0010, jump=3'b111 → halted=1 after the edge. It stays 1 after further increments and clears only when reset is applied. With the macro undefined, halted stays 0.
- Reset priority: reset=1 together with taken=1 and in=16'h0100 → out=RESET_ADDR, jumped=0.
